// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave time-entry path.
// Used by the keypad digit loader, its encoder and its interface.
package microwave_pkg;

   localparam int KEY_COUNT = 10;

   typedef logic [3:0] bcd_t;

   // Largest digit that may be shifted into the mod-6 tens-of-seconds stage.
   localparam bcd_t MAX_TENS_DIGIT = 4'd5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CLR,
      WAIT_REL
   } loader_state_t;

endpackage

// File: rtl/keypad_digit_loader_if.sv
// Keypad-side inputs and counter-side strobes of the digit loader, plus FSM state for debug.
// Handshake: loadn/timer_clearn are active-low single-cycle strobes; digit is stable while loadn is low.
interface keypad_digit_loader_if;
   import microwave_pkg::*;

   logic [KEY_COUNT-1:0] keypad;
   logic                 entry_enable;
   logic                 cancel;
   bcd_t                 digit;
   logic                 loadn;
   logic                 timer_clearn;
   logic [1:0]           digit_count;
   logic                 key_error;
   loader_state_t        state;

   modport master (
      output keypad, entry_enable, cancel,
      input  digit, loadn, timer_clearn, digit_count, key_error, state
   );

   modport slave (
      input  keypad, entry_enable, cancel,
      output digit, loadn, timer_clearn, digit_count, key_error, state
   );

endinterface

// File: rtl/keypad_encoder10.sv
// Combinational 10-key encoder: key index plus one-hot / multi-press flags.
module keypad_encoder10
   import microwave_pkg::*;
(
   input  logic [KEY_COUNT-1:0] keys,
   output bcd_t                 value,
   output logic                 onehot,
   output logic                 multi
);

   logic [3:0] hits;

   always_comb begin
      value = '0;
      hits  = '0;
      for (int i = 0; i < KEY_COUNT; i++) begin
         if (keys[i]) begin
            value = bcd_t'(i);
            hits  = hits + 4'd1;
         end
      end
      onehot = (hits == 4'd1);
      multi  = (hits > 4'd1);
   end

endmodule

// File: rtl/keypad_digit_loader.sv
// Turns raw keypad presses into validated single-cycle digit loads for the mm:ss counter.
// Optional debounce front end enabled with `define KEYPAD_DEBOUNCE_EN.
module keypad_digit_loader
   import microwave_pkg::*;
#(
   parameter int MAX_DIGITS = 3
`ifdef KEYPAD_DEBOUNCE_EN
   , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
   input logic                  CLK,
   input logic                  clear,
   keypad_digit_loader_if.slave kif
);

   logic [KEY_COUNT-1:0] keys_q, keys_d;
   loader_state_t        state_q, state_d;
   bcd_t                 digit_q, digit_d;
   bcd_t                 last_digit_q, last_digit_d;
   logic [1:0]           digit_count_q, digit_count_d;
   logic                 loadn_q, loadn_d;
   logic                 timer_clearn_q, timer_clearn_d;
   logic                 key_error_q, key_error_d;
   logic                 armed_q, armed_d;

   bcd_t                 key_value;
   logic                 key_onehot, key_multi;
   logic                 press_onehot, press_multi, press_none;
   logic                 accept_ok, leading_zero;

   keypad_encoder10 u_encoder (
      .keys   (keys_q),
      .value  (key_value),
      .onehot (key_onehot),
      .multi  (key_multi)
   );

   always_comb begin
      keys_d = kif.keypad;
   end

`ifdef KEYPAD_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0]        stable_cnt_q, stable_cnt_d;
   logic [KEY_COUNT-1:0] pattern_q, pattern_d;
   logic                 settled;

   // stable_cnt_d counts consecutive identical samples including the current one.
   always_comb begin
      pattern_d = keys_q;
      if (keys_q == pattern_q) begin
         stable_cnt_d = (stable_cnt_q == CW'(DEBOUNCE_CYCLES)) ? stable_cnt_q : stable_cnt_q + CW'(1);
      end else begin
         stable_cnt_d = CW'(1);
      end
      settled      = (stable_cnt_d == CW'(DEBOUNCE_CYCLES));
      press_onehot = settled && key_onehot;
      press_multi  = settled && key_multi;
      press_none   = settled && (keys_q == '0);
   end
`else
   always_comb begin
      press_onehot = key_onehot;
      press_multi  = key_multi;
      press_none   = (keys_q == '0);
   end
`endif

   always_comb begin
      state_d        = state_q;
      digit_d        = digit_q;
      last_digit_d   = last_digit_q;
      digit_count_d  = digit_count_q;
      loadn_d        = 1'b1;
      timer_clearn_d = 1'b1;
      key_error_d    = 1'b0;
      armed_d        = armed_q | press_none;
      accept_ok      = (digit_count_q < 2'(MAX_DIGITS)) &&
                       ((digit_count_q == 2'd0) || (last_digit_q <= MAX_TENS_DIGIT));
      leading_zero   = (key_value == 4'd0) && (digit_count_q == 2'd0);

      if (kif.cancel && (state_q != CLR)) begin
         state_d        = CLR;
         timer_clearn_d = 1'b0;
         digit_count_d  = 2'd0;
         last_digit_d   = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               // armed_q stays low after clear until the keypad has been seen released.
               if (press_onehot || press_multi) begin
                  state_d = WAIT_REL;
                  if (armed_q && kif.entry_enable) begin
                     if (press_multi) begin
                        key_error_d = 1'b1;
                     end else if (!leading_zero) begin
                        if (accept_ok) begin
                           state_d       = LOAD;
                           loadn_d       = 1'b0;
                           digit_d       = key_value;
                           last_digit_d  = key_value;
                           digit_count_d = digit_count_q + 2'd1;
                        end else begin
                           key_error_d = 1'b1;
                        end
                     end
                  end
               end
            end
            LOAD:     state_d = WAIT_REL;
            CLR:      state_d = WAIT_REL;
            WAIT_REL: if (press_none) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // keys_q is left out of reset so a key held through clear still reads as held.
   always_ff @(posedge CLK) begin
      keys_q <= keys_d;
      if (clear) begin
         state_q        <= IDLE;
         digit_q        <= '0;
         last_digit_q   <= '0;
         digit_count_q  <= '0;
         loadn_q        <= 1'b1;
         timer_clearn_q <= 1'b1;
         key_error_q    <= 1'b0;
         armed_q        <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
         stable_cnt_q   <= '0;
         pattern_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         digit_q        <= digit_d;
         last_digit_q   <= last_digit_d;
         digit_count_q  <= digit_count_d;
         loadn_q        <= loadn_d;
         timer_clearn_q <= timer_clearn_d;
         key_error_q    <= key_error_d;
         armed_q        <= armed_d;
`ifdef KEYPAD_DEBOUNCE_EN
         stable_cnt_q   <= stable_cnt_d;
         pattern_q      <= pattern_d;
`endif
      end
   end

   assign kif.digit        = digit_q;
   assign kif.loadn        = loadn_q;
   assign kif.timer_clearn = timer_clearn_q;
   assign kif.digit_count  = digit_count_q;
   assign kif.key_error    = key_error_q;
   assign kif.state        = state_q;

endmodule
